// File: rtl/cam_gen_pkg.sv
// Shared definitions for the camera stream generator: FSM state codes,
// pattern select codes and the colour-bar palette.
package cam_gen_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VFP    = 3'd1;
  localparam logic [2:0] ST_LINE   = 3'd2;
  localparam logic [2:0] ST_HBLANK = 3'd3;
  localparam logic [2:0] ST_VBLANK = 3'd4;

  localparam logic [1:0] PAT_GRAD  = 2'd0;
  localparam logic [1:0] PAT_BARS  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  // RGB565 colour of each bar, left to right
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = 16'hFFFF;
      3'd1:    c = 16'hFFE0;
      3'd2:    c = 16'h07FF;
      3'd3:    c = 16'h07E0;
      3'd4:    c = 16'hF81F;
      3'd5:    c = 16'hF800;
      3'd6:    c = 16'h001F;
      3'd7:    c = 16'h0000;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_stream_gen_rom.sv
// Combinational test-pattern lookup: maps pixel coordinates, bar index and
// pattern code to one RGB565 pixel.
module cam_pattern_rom
  import cam_gen_pkg::*;
(
  input  logic [5:0]  i_x,
  input  logic [4:0]  i_y,
  input  logic [2:0]  i_bar,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_solid,
  output logic [15:0] o_pix
);

  logic [4:0] w_diag;

  assign w_diag = i_x[4:0] + i_y;

  // Pattern select
  always_comb begin
    o_pix = 16'h0000;
    case (i_pattern)
      PAT_GRAD:  o_pix = {i_y, i_x, w_diag};
      PAT_BARS:  o_pix = bar_colour(i_bar);
      PAT_CHECK: o_pix = (i_x[3] ^ i_y[3]) ? 16'hFFFF : 16'h0000;
      PAT_SOLID: o_pix = i_solid;
      default:   o_pix = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style RGB565 byte-stream generator (VSYNC low frame, HSYNC per line).
// Define CAM_GEN_CHECKSUM_EN to add the oFrameSum per-frame pixel checksum output.
module cam_stream_gen
  import cam_gen_pkg::*;
#(
  parameter int IMG_W    = 480,
  parameter int IMG_H    = 272,
  parameter int VFP_T    = 10,
  parameter int HBLANK_T = 11,
  parameter int VBLANK_T = 100,
  parameter int CLK_DIV  = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iStart,
  input  logic        iContinuous,
  input  logic [1:0]  iPattern,
  input  logic [15:0] iSolid,
  output logic [7:0]  oCamData,
  output logic        oCamHsync,
  output logic        oCamVsync,
  output logic        oPclkEn,
  output logic        oBusy,
  output logic        oFrameDone
`ifdef CAM_GEN_CHECKSUM_EN
  , output logic [31:0] oFrameSum
`endif
);

  localparam int LINE_BYTES = 2 * IMG_W;
  localparam int BAR_W      = IMG_W / 8;
  localparam int M1         = ((LINE_BYTES - 1) > VFP_T) ? (LINE_BYTES - 1) : VFP_T;
  localparam int M2         = (HBLANK_T > VBLANK_T) ? HBLANK_T : VBLANK_T;
  localparam int CNT_MAX    = (M1 > M2) ? M1 : M2;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int XW         = $clog2(IMG_W);
  localparam int YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW        = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [CW-1:0]  VFP_LAST  = CW'(VFP_T - 1);
  localparam logic [CW-1:0]  LINE_LAST = CW'(LINE_BYTES - 1);
  localparam logic [CW-1:0]  HB_LAST   = CW'(HBLANK_T - 1);
  localparam logic [CW-1:0]  VB_LAST   = CW'(VBLANK_T - 1);
  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_H - 1);
  localparam logic [BCW-1:0] BAR_LAST  = BCW'(BAR_W - 1);

  logic [2:0]     r_state;
  logic [DW-1:0]  r_div;
  logic [CW-1:0]  r_cnt;
  logic [XW-1:0]  r_nx;
  logic           r_lo;
  logic [YW-1:0]  r_y;
  logic           r_last;
  logic [2:0]     r_bar;
  logic [BCW-1:0] r_barcnt;
  logic [7:0]     r_pix_lo;
  logic [1:0]     r_pat;
  logic [15:0]    r_solid;

  logic [2:0]  w_nxt_state;
  logic        w_tick;
  logic        w_load;
  logic        w_latch;
  logic        w_done;
  logic [1:0]  w_pat;
  logic [15:0] w_solid;
  logic [15:0] w_pix;
  logic [5:0]  w_x;
  logic [4:0]  w_y;

  assign w_tick  = (r_state != ST_IDLE) && (r_div == DIV_LAST);
  // A frame entry uses the live pattern inputs so a zero-length VFP still sees them
  assign w_pat   = w_latch ? iPattern : r_pat;
  assign w_solid = w_latch ? iSolid : r_solid;
  assign w_x     = 6'(r_nx);
  assign w_y     = 5'(r_y);

  cam_pattern_rom u_rom (
    .i_x       (w_x),
    .i_y       (w_y),
    .i_bar     (r_bar),
    .i_pattern (w_pat),
    .i_solid   (w_solid),
    .o_pix     (w_pix)
  );

  // Next-state decode; w_load marks the edge that drives a new byte
  always_comb begin
    w_nxt_state = r_state;
    w_load      = 1'b0;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_latch = 1'b1;
          if (VFP_T == 0) begin
            w_nxt_state = ST_LINE;
            w_load      = 1'b1;
          end else begin
            w_nxt_state = ST_VFP;
          end
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_VFP: begin
        if (w_tick && (r_cnt == VFP_LAST)) begin
          w_nxt_state = ST_LINE;
          w_load      = 1'b1;
        end else begin
          w_nxt_state = ST_VFP;
        end
      end
      ST_LINE: begin
        if (w_tick && (r_cnt == LINE_LAST)) begin
          w_nxt_state = ST_HBLANK;
        end else begin
          w_load = w_tick;
        end
      end
      ST_HBLANK: begin
        if (w_tick && (r_cnt == HB_LAST)) begin
          if (r_last) begin
            w_nxt_state = ST_VBLANK;
          end else begin
            w_nxt_state = ST_LINE;
            w_load      = 1'b1;
          end
        end else begin
          w_nxt_state = ST_HBLANK;
        end
      end
      ST_VBLANK: begin
        if (w_tick && (r_cnt == VB_LAST)) begin
          w_done = 1'b1;
          if (iContinuous) begin
            w_latch = 1'b1;
            if (VFP_T == 0) begin
              w_nxt_state = ST_LINE;
              w_load      = 1'b1;
            end else begin
              w_nxt_state = ST_VFP;
            end
          end else begin
            w_nxt_state = ST_IDLE;
          end
        end else begin
          w_nxt_state = ST_VBLANK;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // State, tick divider and per-state tick counter
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
      r_div   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      if ((r_state == ST_IDLE) || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_nxt_state != r_state) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Pixel walk: r_nx/r_lo/bar point at the next byte to drive, so they wrap by themselves
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_nx     <= '0;
      r_lo     <= 1'b0;
      r_y      <= '0;
      r_last   <= 1'b0;
      r_bar    <= 3'd0;
      r_barcnt <= '0;
      r_pix_lo <= 8'h00;
      r_pat    <= 2'd0;
      r_solid  <= 16'h0000;
    end else begin
      if (w_latch) begin
        r_pat   <= iPattern;
        r_solid <= iSolid;
      end
      if (w_load && !r_lo) begin
        r_pix_lo <= w_pix[7:0];
        r_lo     <= 1'b1;
      end else if (w_load) begin
        r_lo <= 1'b0;
        r_nx <= (r_nx == X_LAST) ? '0 : r_nx + XW'(1);
        if (r_barcnt == BAR_LAST) begin
          r_barcnt <= '0;
          r_bar    <= r_bar + 3'd1;
        end else begin
          r_barcnt <= r_barcnt + BCW'(1);
        end
      end
      if ((r_state == ST_LINE) && (w_nxt_state == ST_HBLANK)) begin
        r_last <= (r_y == Y_LAST);
        r_y    <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
      end else if ((r_state == ST_HBLANK) && (w_nxt_state != ST_HBLANK)) begin
        r_last <= 1'b0;
      end
    end
  end

  // Registered stream outputs, decoded from the next state
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oCamData   <= 8'h00;
      oCamHsync  <= 1'b0;
      oCamVsync  <= 1'b1;
      oPclkEn    <= 1'b0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      if (w_load) begin
        oCamData <= r_lo ? r_pix_lo : w_pix[15:8];
      end else if (w_nxt_state != ST_LINE) begin
        oCamData <= 8'h00;
      end
      oCamHsync  <= (w_nxt_state == ST_LINE);
      oCamVsync  <= (w_nxt_state == ST_IDLE) || (w_nxt_state == ST_VBLANK);
      oPclkEn    <= w_load;
      oBusy      <= (w_nxt_state != ST_IDLE);
      oFrameDone <= w_done;
    end
  end

`ifdef CAM_GEN_CHECKSUM_EN
  // Frame checksum: restarts at frame entry, one add per pixel on its high byte
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oFrameSum <= 32'd0;
    end else if (w_load && !r_lo) begin
      oFrameSum <= (w_latch ? 32'd0 : oFrameSum) + {16'h0000, w_pix};
    end else if (w_latch) begin
      oFrameSum <= 32'd0;
    end
  end
`endif

endmodule

// File: tb/tb_cam_stream_gen.sv
// Scoreboard bench for cam_stream_gen: directed frames push expected bytes,
// a monitor pops and compares on every oPclkEn strobe.
module tb_cam_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_start, a_cont, b_start, b_cont;
  logic [1:0] a_pat, b_pat;
  logic [15:0] a_solid, b_solid;
  logic [7:0] a_data, b_data;
  logic a_hs, a_vs, a_pe, a_busy, a_done;
  logic b_hs, b_vs, b_pe, b_busy, b_done;
`ifdef CAM_GEN_CHECKSUM_EN
  logic [31:0] a_sum, b_sum;
`endif

  cam_stream_gen #(.IMG_W(8), .IMG_H(2), .VFP_T(2), .HBLANK_T(3), .VBLANK_T(4), .CLK_DIV(1)) dut_a (
    .iClk(clk), .iRst_n(rst_n), .iStart(a_start), .iContinuous(a_cont),
    .iPattern(a_pat), .iSolid(a_solid), .oCamData(a_data), .oCamHsync(a_hs),
    .oCamVsync(a_vs), .oPclkEn(a_pe), .oBusy(a_busy), .oFrameDone(a_done)
`ifdef CAM_GEN_CHECKSUM_EN
    , .oFrameSum(a_sum)
`endif
  );

  cam_stream_gen #(.IMG_W(16), .IMG_H(2), .VFP_T(2), .HBLANK_T(3), .VBLANK_T(4), .CLK_DIV(4)) dut_b (
    .iClk(clk), .iRst_n(rst_n), .iStart(b_start), .iContinuous(b_cont),
    .iPattern(b_pat), .iSolid(b_solid), .oCamData(b_data), .oCamHsync(b_hs),
    .oCamVsync(b_vs), .oPclkEn(b_pe), .oBusy(b_busy), .oFrameDone(b_done)
`ifdef CAM_GEN_CHECKSUM_EN
    , .oFrameSum(b_sum)
`endif
  );

  // Gradient for W=8, H=2: line 0 then line 1
  localparam logic [15:0] GRAD [16] = '{
    16'h0000, 16'h0021, 16'h0042, 16'h0063, 16'h0084, 16'h00A5, 16'h00C6, 16'h00E7,
    16'h0801, 16'h0822, 16'h0843, 16'h0864, 16'h0885, 16'h08A6, 16'h08C7, 16'h08E8};
  localparam logic [15:0] BARS16 [16] = '{
    16'hFFFF, 16'hFFFF, 16'hFFE0, 16'hFFE0, 16'h07FF, 16'h07FF, 16'h07E0, 16'h07E0,
    16'hF81F, 16'hF81F, 16'hF800, 16'hF800, 16'h001F, 16'h001F, 16'h0000, 16'h0000};

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int b_cyc = 0, b_last_pe = 0, b_pulses = 0;
  logic b_hs_q = 1'b0;
  logic [7:0] b_data_q = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_a(input logic [15:0] p);
    exp_a.push_back(p[15:8]);
    exp_a.push_back(p[7:0]);
  endtask

  task automatic push_b(input logic [15:0] p);
    exp_b.push_back(p[15:8]);
    exp_b.push_back(p[7:0]);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (a_pe) begin
        if (exp_a.size() == 0) chk("a_extra_byte", {24'd0, a_data}, 32'hFFFF_FFFF);
        else chk("a_byte", {24'd0, a_data}, {24'd0, exp_a.pop_front()});
      end
      b_cyc++;
      if (b_pe) begin
        if (exp_b.size() == 0) chk("b_extra_byte", {24'd0, b_data}, 32'hFFFF_FFFF);
        else chk("b_byte", {24'd0, b_data}, {24'd0, exp_b.pop_front()});
        if (b_pulses > 0) chk("b_pclk_gap", 32'(b_cyc - b_last_pe), 32'd4);
        b_last_pe = b_cyc;
        b_pulses++;
      end else if (b_hs && b_hs_q) begin
        chk("b_data_hold", {24'd0, b_data}, {24'd0, b_data_q});
      end
      if (!b_hs && b_hs_q) begin
        chk("b_pulses_per_line", 32'(b_pulses), 32'd32);
        b_pulses = 0;
      end
      b_hs_q   = b_hs;
      b_data_q = b_data;
    end
  endtask

  task automatic wait_a_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_done && n < 500);
    chk(name, {31'd0, a_done}, 32'd1);
  endtask

  task automatic wait_b_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_done && n < 2000);
    chk(name, {31'd0, b_done}, 32'd1);
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic check_a_idle(input string name);
    chk({name, "_vsync"}, {31'd0, a_vs}, 32'd1);
    chk({name, "_hsync"}, {31'd0, a_hs}, 32'd0);
    chk({name, "_data"}, {24'd0, a_data}, 32'd0);
    chk({name, "_busy"}, {31'd0, a_busy}, 32'd0);
    chk({name, "_pclk"}, {31'd0, a_pe}, 32'd0);
    chk({name, "_done"}, {31'd0, a_done}, 32'd0);
  endtask

  task automatic run();
    int k;
    rst_n = 1'b0;
    a_start = 1'b0; a_cont = 1'b0; a_pat = 2'd0; a_solid = 16'h0000;
    b_start = 1'b0; b_cont = 1'b0; b_pat = 2'd0; b_solid = 16'h0000;
    repeat (3) @(negedge clk);
    check_a_idle("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_a_idle("idle");

    // Gradient frame with latency checks
    for (int i = 0; i < 16; i++) push_a(GRAD[i]);
    pulse_a_start();
    chk("a_vsync_low_k1", {31'd0, a_vs}, 32'd0);
    chk("a_busy_k1", {31'd0, a_busy}, 32'd1);
    chk("a_hsync_k1", {31'd0, a_hs}, 32'd0);
    @(negedge clk);
    chk("a_hsync_k2", {31'd0, a_hs}, 32'd0);
    @(negedge clk);
    chk("a_hsync_k3", {31'd0, a_hs}, 32'd1);
    k = 3;
    while (!a_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("a_frame_done_latency", 32'(k), 32'd45);
    chk("a_busy_at_done", {31'd0, a_busy}, 32'd0);
    chk("a_vsync_at_done", {31'd0, a_vs}, 32'd1);
    @(negedge clk);
    chk("a_done_one_cycle", {31'd0, a_done}, 32'd0);
    chk("a_grad_queue_empty", 32'(exp_a.size()), 32'd0);

    // Colour bars then checkerboard on the divided, wider instance
    b_pat = 2'd1;
    for (int y = 0; y < 2; y++)
      for (int i = 0; i < 16; i++) push_b(BARS16[i]);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_b_done("b_bars_done");
    chk("b_bars_queue_empty", 32'(exp_b.size()), 32'd0);
    b_pat = 2'd2;
    for (int y = 0; y < 2; y++)
      for (int i = 0; i < 16; i++) push_b((i < 8) ? 16'h0000 : 16'hFFFF);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_b_done("b_check_done");
    chk("b_check_queue_empty", 32'(exp_b.size()), 32'd0);
`ifdef CAM_GEN_CHECKSUM_EN
    chk("b_check_sum", b_sum, 32'h000F_FFF0);
`endif
    @(negedge clk);
    chk("b_busy_after", {31'd0, b_busy}, 32'd0);
    chk("b_vsync_after", {31'd0, b_vs}, 32'd1);

    // Continuous: pattern change in frame 1 takes effect from frame 2
    a_pat = 2'd3; a_solid = 16'h1234; a_cont = 1'b1;
    for (int i = 0; i < 16; i++) push_a(16'h1234);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) push_a(GRAD[i]);
    pulse_a_start();
    k = 0;
    while (!a_hs && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("a_cont_line_seen", {31'd0, a_hs}, 32'd1);
    a_pat = 2'd0;
    wait_a_done("a_cont_done1");
    chk("a_cont_busy1", {31'd0, a_busy}, 32'd1);
    wait_a_done("a_cont_done2");
    a_cont = 1'b0;
    wait_a_done("a_cont_done3");
    chk("a_cont_busy3", {31'd0, a_busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("a_cont_stays_idle", {31'd0, a_busy}, 32'd0);
    chk("a_cont_queue_empty", 32'(exp_a.size()), 32'd0);

    // Reset in the middle of line 1, then a clean solid frame
    for (int i = 0; i < 16; i++) push_a(GRAD[i]);
    pulse_a_start();
    k = 0;
    while (!(a_hs && a_data == 8'h08) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("a_line1_reached", {24'd0, a_data}, 32'h08);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_a_idle("midreset");
    exp_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_pat = 2'd3; a_solid = 16'h1234;
    for (int i = 0; i < 16; i++) push_a(16'h1234);
    pulse_a_start();
    wait_a_done("a_post_reset_done");
    chk("a_post_reset_queue_empty", 32'(exp_a.size()), 32'd0);
`ifdef CAM_GEN_CHECKSUM_EN
    chk("a_solid_sum", a_sum, 32'h0001_2340);
`endif
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
